// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: takes a WIDTH-bit word over valid/ready and shifts it out
// one bit per clock, optionally followed by a fixed number of idle cycles.
module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din_data,
    output logic             din_ready,
    output logic             dout_bit,
    output logic             dout_valid,
    output logic             done,
    output logic             busy
);

    localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_PENULT = CW'(WIDTH - 2);
    localparam logic [7:0]    GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    bit_cnt, bit_cnt_next;
    logic [7:0]       gap_cnt, gap_cnt_next;
    logic             dout_bit_next, dout_valid_next, done_next;
    logic             last_bit, transfer;
    logic             load_bit, shift_bit;
    logic [WIDTH-1:0] load_shreg, shifted_shreg;

    assign last_bit  = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign din_ready = !rst && ((state == IDLE) || (last_bit && (GAP_CYCLES == 0)));
    assign transfer  = din_valid && din_ready;
    assign busy      = (state != IDLE);

    // The first bit goes straight to dout_bit on the transfer edge, so the shift
    // register holds only the bits still to come.
    always_comb begin
        if (MSB_FIRST) begin
            load_bit      = din_data[WIDTH-1];
            load_shreg    = {din_data[WIDTH-2:0], 1'b0};
            shift_bit     = shreg[WIDTH-1];
            shifted_shreg = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            load_bit      = din_data[0];
            load_shreg    = {1'b0, din_data[WIDTH-1:1]};
            shift_bit     = shreg[0];
            shifted_shreg = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        bit_cnt_next    = bit_cnt;
        gap_cnt_next    = gap_cnt;
        dout_bit_next   = IDLE_BIT;
        dout_valid_next = 1'b0;
        done_next       = 1'b0;

        if (transfer) begin
            state_next      = SHIFT;
            shreg_next      = load_shreg;
            bit_cnt_next    = '0;
            dout_bit_next   = load_bit;
            dout_valid_next = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                end
                SHIFT: begin
                    if (!last_bit) begin
                        shreg_next      = shifted_shreg;
                        bit_cnt_next    = bit_cnt + CW'(1);
                        dout_bit_next   = shift_bit;
                        dout_valid_next = 1'b1;
                        done_next       = (bit_cnt == BIT_PENULT);
                    end else if (GAP_CYCLES > 0) begin
                        state_next   = GAP;
                        bit_cnt_next = '0;
                        gap_cnt_next = '0;
                    end else begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_next   = IDLE;
                        gap_cnt_next = '0;
                    end else begin
                        gap_cnt_next = gap_cnt + 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dout_bit   <= IDLE_BIT;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            gap_cnt    <= gap_cnt_next;
            dout_bit   <= dout_bit_next;
            dout_valid <= dout_valid_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first/no-gap instance and an LSB-first/3-cycle-gap instance,
// checked every cycle against a position-in-word reference model.
module tb_bit_serializer;

    localparam int WIDTH = 8;
    localparam int GAP_B = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       din_valid, din_ready, dout_bit, dout_valid, done, busy;
    logic [WIDTH-1:0] din_data [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: a word is active for WIDTH data cycles plus its gap cycles.
    bit               active [2];
    int               pos    [2];
    logic [WIDTH-1:0] word   [2];

    int               vcount [2];
    int               dcount [2];
    int               ones   [2];
    int               run    [2];
    int               maxrun [2];
    logic [WIDTH-1:0] cap    [2];

    string nm [2] = '{"a", "b"};

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid[0]),
        .din_data   (din_data[0]),
        .din_ready  (din_ready[0]),
        .dout_bit   (dout_bit[0]),
        .dout_valid (dout_valid[0]),
        .done       (done[0]),
        .busy       (busy[0])
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP_B), .IDLE_BIT(1'b1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid[1]),
        .din_data   (din_data[1]),
        .din_ready  (din_ready[1]),
        .dout_bit   (dout_bit[1]),
        .dout_valid (dout_valid[1]),
        .done       (done[1]),
        .busy       (busy[1])
    );

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : GAP_B;
    endfunction

    function automatic logic idle_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_ready(input int i);
        return !rst && (!active[i] || ((pos[i] == WIDTH - 1) && (gap_of(i) == 0)));
    endfunction

    function automatic logic exp_valid(input int i);
        return active[i] && (pos[i] < WIDTH);
    endfunction

    function automatic logic exp_bit(input int i);
        if (!exp_valid(i))
            return idle_of(i);
        return (i == 0) ? word[i][WIDTH - 1 - pos[i]] : word[i][pos[i]];
    endfunction

    function automatic logic exp_done(input int i);
        return active[i] && (pos[i] == WIDTH - 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                active[i] = 1'b0;
                pos[i]    = 0;
            end else if (din_valid[i] && exp_ready(i)) begin
                active[i] = 1'b1;
                pos[i]    = 0;
                word[i]   = din_data[i];
            end else if (active[i]) begin
                pos[i]++;
                if (pos[i] >= WIDTH + gap_of(i)) begin
                    active[i] = 1'b0;
                    pos[i]    = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] v,
                                 input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        rst         = r;
        din_valid   = v;
        din_data[0] = da;
        din_data[1] = db;
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 2; i++) begin
            vcount[i] = 0;
            dcount[i] = 0;
            ones[i]   = 0;
            run[i]    = 0;
            maxrun[i] = 0;
            cap[i]    = '0;
        end
    endtask

    // One clock: compare every output of both instances mid-cycle and accumulate stream stats.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput({nm[i], ".din_ready"},  din_ready[i],  exp_ready(i));
            checkOutput({nm[i], ".dout_valid"}, dout_valid[i], exp_valid(i));
            checkOutput({nm[i], ".dout_bit"},   dout_bit[i],   exp_bit(i));
            checkOutput({nm[i], ".done"},       done[i],       exp_done(i));
            checkOutput({nm[i], ".busy"},       busy[i],       active[i]);
            if (dout_valid[i] === 1'b1) begin
                vcount[i]++;
                cap[i] = {cap[i][WIDTH-2:0], dout_bit[i]};
                if (dout_bit[i] === 1'b1)
                    ones[i]++;
                run[i]++;
                if (run[i] > maxrun[i])
                    maxrun[i] = run[i];
            end else begin
                run[i] = 0;
            end
            if (done[i] === 1'b1)
                dcount[i]++;
        end
    endtask

    initial begin
        clearCounts();

        // Reset held for two cycles, then released
        applyStimulus(1'b1, 2'b00, 8'hxx, 8'hxx);
        tick();
        tick();
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        tick();
        checkCount("ready after reset a", int'(din_ready[0]), 1);

        // Single word on each instance
        clearCounts();
        applyStimulus(1'b0, 2'b11, 8'b0101_0011, 8'hA1);
        tick();
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        repeat (11) tick();
        checkCount("single msb stream", int'(cap[0]), 'h53);
        checkCount("single msb valid cycles", vcount[0], 8);
        checkCount("single msb done count", dcount[0], 1);
        checkCount("single lsb stream", int'(cap[1]), 'h85);
        checkCount("single lsb done count", dcount[1], 1);

        // Back-to-back words FF then 00 with valid held through the second transfer
        clearCounts();
        applyStimulus(1'b0, 2'b01, 8'hFF, 8'hxx);
        tick();
        applyStimulus(1'b0, 2'b01, 8'h00, 8'hxx);
        repeat (8) tick();
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        repeat (10) tick();
        checkCount("b2b unbroken valid run", maxrun[0], 16);
        checkCount("b2b ones", ones[0], 8);
        checkCount("b2b done count", dcount[0], 2);

        // Gapped stream: valid held on the gap instance for 36 cycles gives three words
        clearCounts();
        for (int c = 0; c < 36; c++) begin
            applyStimulus(1'b0, 2'b10, 8'hxx, 8'($urandom));
            tick();
        end
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        tick();
        checkCount("gap valid cycles", vcount[1], 24);
        checkCount("gap done count", dcount[1], 3);

        // Reset during the bit-3 cycle aborts the word
        clearCounts();
        applyStimulus(1'b0, 2'b01, 8'($urandom), 8'hxx);
        tick();
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        repeat (3) tick();
        applyStimulus(1'b1, 2'b00, 8'hxx, 8'hxx);
        tick();
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        repeat (5) tick();
        checkCount("abort valid cycles", vcount[0], 4);
        checkCount("abort done count", dcount[0], 0);

        clearCounts();
        applyStimulus(1'b0, 2'b01, 8'hC6, 8'hxx);
        tick();
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        repeat (9) tick();
        checkCount("post-abort stream", int'(cap[0]), 'hC6);
        checkCount("post-abort done count", dcount[0], 1);

        // Random traffic with occasional resets; data is X whenever valid is low
        for (int c = 0; c < 400; c++) begin
            logic [1:0] v;
            v = 2'($urandom);
            applyStimulus(($urandom_range(0, 63) == 0), v,
                          v[0] ? 8'($urandom) : 8'hxx,
                          v[1] ? 8'($urandom) : 8'hxx);
            tick();
        end
        applyStimulus(1'b0, 2'b00, 8'hxx, 8'hxx);
        repeat (15) tick();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the sequence-detector FSM. Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on dout_bit, which drives the detector's din_bit. It supports back-to-back streaming and a programmable idle gap between words, so that pattern boundaries can be exercised deterministically.

Parameters:
WIDTH, 8, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
GAP_CYCLES, 0, number of idle cycles inserted after each word (0..255).
IDLE_BIT, 0, level driven on dout_bit whenever no data bit is being sent.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
din_valid  input  1  upstream has a word on din_data
din_data  input  WIDTH  parallel word to serialize
din_ready  output  1  block can accept a word this cycle; combinational from state
dout_bit  output  1  serial data, registered; connects to detector din_bit
dout_valid  output  1  dout_bit carries a data bit this cycle, registered
done  output  1  one-cycle pulse coincident with the last bit of a word, registered
busy  output  1  high in SHIFT or GAP state

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - dout_bit=IDLE_BIT, dout_valid=0, done=0, busy=0.
  - din_ready=0 while rst=1, then 1 in the first cycle after rst falls.
- Reset mid-word aborts the word immediately. The remaining bits are discarded and never emitted.
- States:
  - IDLE: din_ready=1, dout_valid=0, dout_bit=IDLE_BIT.
  - SHIFT: emits bits. The bit counter runs 0..WIDTH-1, sized clog2(WIDTH).
  - GAP: din_ready=0, dout_valid=0, dout_bit=IDLE_BIT. The gap counter runs 0..GAP_CYCLES-1.
- Handshake: a transfer occurs at a rising edge where din_valid && din_ready. din_data is sampled only at that edge; later changes to din_data are ignored.
- Latency: if the transfer happens at edge k, the first data bit appears on dout_bit with dout_valid=1 after edge k (the cycle k+1). Bit i appears in cycle k+1+i.
- Bit order: MSB_FIRST=1 sends din_data[WIDTH-1] down to [0]. MSB_FIRST=0 sends [0] up to [WIDTH-1].
- done=1 exactly during the cycle carrying the last bit; otherwise 0.
- Transitions:
  - IDLE -> SHIFT on a transfer.
  - SHIFT, last bit, GAP_CYCLES=0: din_ready=1 during the last-bit cycle.
    - If a transfer occurs, stay in SHIFT and reload. The new word's first bit follows with no bubble, so dout_valid stays high.
    - If no transfer, go to IDLE.
  - SHIFT, last bit, GAP_CYCLES>0: din_ready=0; go to GAP.
  - GAP -> IDLE after GAP_CYCLES cycles spent in GAP.
- din_ready=0 in SHIFT except during the last-bit cycle when GAP_CYCLES=0. din_valid is ignored while din_ready=0.
- din_valid held high continuously with GAP_CYCLES=0 produces an unbroken stream, one word every WIDTH cycles.
- No X propagates to outputs when din_data is X and din_valid=0.

Test Plan:
- Reset check: rst=1 for 2 cycles, then released. Required: dout_bit=0, dout_valid=0, done=0, busy=0 during reset; din_ready=1 in the first cycle after release.
- Single word, MSB_FIRST=1, WIDTH=8: din_data=8'b0101_0011, 1-cycle valid pulse. Required: dout_bit=0,1,0,1,0,0,1,1 in cycles k+1..k+8; done only at k+8; IDLE from k+9 with dout_bit=0. Chained into top_fsm, exactly 3 dout_bit pulses from the detector.
- LSB-first: MSB_FIRST=0, din_data=8'hA1. Required: bit stream 1,0,0,0,0,1,0,1.
- Back-to-back: GAP_CYCLES=0, din_valid held with words 8'hFF then 8'h00. Required: 16 consecutive cycles with dout_valid=1; second transfer accepted in the last-bit cycle of the first; done at cycles 8 and 16.
- Gap: GAP_CYCLES=3, din_valid held high. Required: 3 cycles with dout_valid=0, dout_bit=IDLE_BIT and din_ready=0 after each word, then din_ready=1 for one IDLE cycle before the next word starts.
- Mid-word reset: rst=1 in the cycle carrying bit 3. Required: outputs return to reset values on the next edge; no remaining bits or done pulse appear; the next word after reset serializes normally.
